// File: rtl/cache_write_merge.sv
// rtl/cache_write_merge.sv - LC3B cache write-merge stage (read line, merge one word, write line back)
//
// Purpose: accepts a single 16-bit CPU write with byte enables, reads the
// addressed line from the data array, replaces the selected word (byte by
// byte), and writes the merged line back.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   req_valid/ready    write request handshake
//   req_offset         word offset within the line
//   req_wdata          16-bit write data
//   req_byte_enable    bit0 = low byte, bit1 = high byte
//   arr_read           read request to the data array (held until arr_rvalid)
//   arr_rdata/rvalid   line returned by the array, qualified by arr_rvalid
//   arr_write          write request to the data array (held until arr_wready)
//   arr_wdata          merged line; word k at [k*16+15:k*16]
//   arr_wready         array accepts the write this cycle
//   done               one-cycle pulse in the cycle the write is accepted
//   merge_count        (CACHE_MERGE_STATS_EN only) saturating count of done pulses
//
// Build option: define CACHE_MERGE_STATS_EN to add the merge_count port and counter.

module cache_write_merge #(
  parameter int WORDS  = 8,
  parameter int WORD_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [$clog2(WORDS)-1:0]  req_offset,
  input  logic [WORD_W-1:0]         req_wdata,
  input  logic [1:0]                req_byte_enable,
  output logic                      arr_read,
  input  logic [WORDS*WORD_W-1:0]   arr_rdata,
  input  logic                      arr_rvalid,
  output logic                      arr_write,
  output logic [WORDS*WORD_W-1:0]   arr_wdata,
  input  logic                      arr_wready,
  output logic                      done
`ifdef CACHE_MERGE_STATS_EN
  ,
  output logic [15:0]               merge_count
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int LINE_W = WORDS * WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [OFF_W-1:0]  off_q;
  logic [WORD_W-1:0] wdata_q;
  logic [1:0]        be_q;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] merged_q;
  logic [LINE_W-1:0] merged_next;
  logic [WORDS-1:0]  word_en;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid)  state_next = READ;
      READ:    if (arr_rvalid) state_next = MERGE;
      MERGE:                   state_next = WRITE;
      WRITE:   if (arr_wready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; done also needs the write acceptance
  always_comb begin
    req_ready = (state == IDLE);
    arr_read  = (state == READ);
    arr_write = (state == WRITE);
    done      = (state == WRITE) && arr_wready;
  end

  // One-hot word select, then per-byte replacement inside the selected word
  always_comb begin
    word_en     = '0;
    merged_next = line_q;
    for (int k = 0; k < WORDS; k++) begin
      word_en[k] = (off_q == OFF_W'(k));
      if (word_en[k]) begin
        if (be_q[0]) merged_next[k*WORD_W +: 8]     = wdata_q[7:0];
        if (be_q[1]) merged_next[k*WORD_W + 8 +: 8] = wdata_q[15:8];
      end
    end
  end

  // Datapath registers; request fields only load in IDLE so a request
  // arriving while busy cannot disturb the one in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      line_q   <= '0;
      merged_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        off_q   <= req_offset;
        wdata_q <= req_wdata;
        be_q    <= req_byte_enable;
      end
      if (state == READ && arr_rvalid) begin
        line_q <= arr_rdata;
      end
      if (state == MERGE) begin
        merged_q <= merged_next;
      end
    end
  end

  assign arr_wdata = merged_q;

`ifdef CACHE_MERGE_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (done && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign merge_count = count_q;
`endif

endmodule

// File: tb/tb_cache_write_merge.sv
// tb/tb_cache_write_merge.sv - self-checking bench for cache_write_merge

module tb_cache_write_merge;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_offset = '0;
  logic [15:0]  req_wdata = '0;
  logic [1:0]   req_byte_enable = '0;
  logic         arr_read;
  logic [127:0] arr_rdata = '0;
  logic         arr_rvalid = 1'b0;
  logic         arr_write;
  logic [127:0] arr_wdata;
  logic         arr_wready = 1'b0;
  logic         done;
`ifdef CACHE_MERGE_STATS_EN
  logic [15:0]  merge_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cache_write_merge #(.WORDS(8), .WORD_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_offset(req_offset),
    .req_wdata(req_wdata),
    .req_byte_enable(req_byte_enable),
    .arr_read(arr_read),
    .arr_rdata(arr_rdata),
    .arr_rvalid(arr_rvalid),
    .arr_write(arr_write),
    .arr_wdata(arr_wdata),
    .arr_wready(arr_wready),
    .done(done)
`ifdef CACHE_MERGE_STATS_EN
    ,
    .merge_count(merge_count)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs checked 1 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Byte-level reference: byte b belongs to word b/2, half b%2.
  function automatic logic [127:0] ref_merge(input logic [127:0] line, input int off,
                                             input logic [15:0] wd, input logic [1:0] be);
    logic [127:0] r;
    r = line;
    for (int b = 0; b < 16; b++)
      if ((b / 2) == off && be[b % 2]) r[b*8 +: 8] = wd[(b % 2)*8 +: 8];
    return r;
  endfunction

  // One complete transaction. Caller is positioned in an IDLE cycle.
  task automatic run_txn(input string name, input logic [2:0] off, input logic [15:0] wd,
                         input logic [1:0] be, input logic [127:0] line, input logic [127:0] exp,
                         input int rdel, input int wdel, input bit poke_busy);
    req_valid = 1'b1; req_offset = off; req_wdata = wd; req_byte_enable = be;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || arr_read !== 1'b0 || arr_write !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept: ready=%b read=%b write=%b required 1 0 0", name, req_ready, arr_read, arr_write);
    end
    step();
    req_valid = poke_busy;
    if (poke_busy) begin
      req_offset = ~off; req_wdata = ~wd; req_byte_enable = ~be;
    end
    for (int i = 0; i <= rdel; i++) begin
      arr_rvalid = (i == rdel);
      arr_rdata  = (i == rdel) ? line : rand_line();
      #1;
      n_cmp++;
      if (arr_read !== 1'b1 || arr_write !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s read[%0d]: read=%b write=%b done=%b ready=%b required 1 0 0 0", name, i, arr_read, arr_write, done, req_ready);
      end
      step();
    end
    arr_rvalid = 1'b0; arr_rdata = rand_line();
    arr_wready = 1'b1;
    #1;
    n_cmp++;
    if (arr_read !== 1'b0 || arr_write !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s merge: read=%b write=%b done=%b ready=%b required 0 0 0 0", name, arr_read, arr_write, done, req_ready);
    end
    step();
    for (int j = 0; j <= wdel; j++) begin
      arr_wready = (j == wdel);
      if (j == wdel) req_valid = 1'b0;
      #1;
      n_cmp++;
      if (arr_write !== 1'b1 || arr_read !== 1'b0 || done !== (j == wdel) || arr_wdata !== exp) begin
        n_fail++;
        $display("FAIL %s write[%0d]: write=%b read=%b done=%b wdata=%h required 1 0 %b %h", name, j, arr_write, arr_read, done, arr_wdata, (j == wdel), exp);
      end
      step();
    end
    arr_wready = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || arr_write !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s post: ready=%b write=%b done=%b required 1 0 0", name, req_ready, arr_write, done);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1 || arr_read !== 1'b0 || arr_write !== 1'b0 || done !== 1'b0 || arr_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: ready=%b read=%b write=%b done=%b wdata=%h required 1 0 0 0 0", req_ready, arr_read, arr_write, done, arr_wdata);
    end
    step();
    rst = 1'b0;
    // Array qualifiers toggling in IDLE must be ignored
    for (int i = 0; i < 10; i++) begin
      arr_rvalid = i[0]; arr_wready = ~i[0]; arr_rdata = rand_line();
      #1;
      n_cmp++;
      if (req_ready !== 1'b1 || arr_read !== 1'b0 || arr_write !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle[%0d]: ready=%b read=%b write=%b done=%b required 1 0 0 0", i, req_ready, arr_read, arr_write, done);
      end
      step();
    end
    arr_rvalid = 1'b0; arr_wready = 1'b0;
  endtask

  task automatic test_directed();
    run_txn("off3_beef", 3'd3, 16'hBEEF, 2'b11, '0,
            128'h0000_0000_0000_0000_BEEF_0000_0000_0000, 0, 0, 1'b0);
    run_txn("off7_lowbyte", 3'd7, 16'h1234, 2'b01, {128{1'b1}},
            {16'hFF34, {112{1'b1}}}, 0, 0, 1'b0);
    begin
      logic [127:0] l;
      l = rand_line();
      run_txn("be00_unchanged", 3'd5, 16'h5A5A, 2'b00, l, l, 0, 0, 1'b0);
    end
    run_txn("off0_highbyte", 3'd0, 16'hC3A5, 2'b10, '0,
            128'h0000_0000_0000_0000_0000_0000_0000_C300, 0, 0, 1'b0);
  endtask

  task automatic test_stall_and_busy();
    logic [127:0] l;
    l = rand_line();
    run_txn("stall_busy", 3'd6, 16'h7E81, 2'b11, l, ref_merge(l, 6, 16'h7E81, 2'b11), 4, 3, 1'b1);
  endtask

  task automatic test_reset_in_write();
    req_valid = 1'b1; req_offset = 3'd2; req_wdata = 16'hAAAA; req_byte_enable = 2'b11;
    step();
    req_valid = 1'b0;
    arr_rvalid = 1'b1; arr_rdata = rand_line();
    step();
    arr_rvalid = 1'b0;
    step();
    #1;
    n_cmp++;
    if (arr_write !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_write_pre: write=%b required 1", arr_write);
    end
    arr_wready = 1'b1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (arr_write !== 1'b0 || done !== 1'b0 || arr_wdata !== '0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_write_async: write=%b done=%b wdata=%h ready=%b required 0 0 0 1", arr_write, done, arr_wdata, req_ready);
    end
    step();
    #1;
    n_cmp++;
    if (arr_write !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_write_hold: write=%b done=%b required 0 0", arr_write, done);
    end
    rst = 1'b0; arr_wready = 1'b0;
    step();
    begin
      logic [127:0] l;
      l = rand_line();
      run_txn("after_reset", 3'd1, 16'h0F0F, 2'b11, l, ref_merge(l, 1, 16'h0F0F, 2'b11), 1, 0, 1'b0);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [2:0]   off;
      logic [15:0]  wd;
      logic [1:0]   be;
      logic [127:0] l;
      off = 3'($urandom_range(0, 7));
      wd  = 16'($urandom);
      be  = 2'($urandom_range(0, 3));
      l   = rand_line();
      run_txn($sformatf("rand%0d", t), off, wd, be, l, ref_merge(l, int'(off), wd, be),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 5; t++) begin
      logic [127:0] l;
      logic [15:0]  wd;
      l  = rand_line();
      wd = 16'($urandom);
      run_txn($sformatf("b2b%0d", t), 3'(t), wd, 2'b11, l, ref_merge(l, t, wd, 2'b11), 0, 0, 1'b0);
    end
  endtask

`ifdef CACHE_MERGE_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    test_back_to_back();
    n_cmp++;
    if (merge_count !== 16'd5) begin
      n_fail++;
      $display("FAIL stats_count: merge_count=%0d required 5", merge_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_stall_and_busy();
    test_reset_in_write();
    test_random();
    test_back_to_back();
`ifdef CACHE_MERGE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
